// File: rtl/rsa_modexp_sched.sv
// Job scheduler sharing one modular-exponentiation core among NREQ requesters.
// Round-robin arbitration, operand latching, exponent bit-length, core
// init/next sequencing with per-phase timeout, and result return.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester keeps req_valid_i high until it sees req_ready_o
// (a one-cycle pulse). rsp_valid_o stays high with stable data/err until
// the owning requester's rsp_ready_i is sampled high.
module rsa_modexp_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*DW-1:0]       req_msg_i,
  input  logic [NREQ*DW-1:0]       req_exp_i,
  input  logic [NREQ*DW-1:0]       req_mod_i,
  output logic [NREQ-1:0]          rsp_valid_o,
  input  logic [NREQ-1:0]          rsp_ready_i,
  output logic [DW-1:0]            rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     core_init_o,
  output logic                     core_next_o,
  input  logic                     core_ready_i,
  output logic [DW-1:0]            core_msg_o,
  output logic [DW-1:0]            core_exp_o,
  output logic [DW-1:0]            core_mod_o,
  output logic [5:0]               core_exp_len_o,
  input  logic [DW-1:0]            core_result_i,
  output logic                     busy_o,
  output logic [$clog2(NREQ)-1:0]  grant_o,
  output logic [2:0]               dbg_state_o
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_WAIT_INIT = 3'd2,
    S_NEXT      = 3'd3,
    S_WAIT_NEXT = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   scan;

  logic [DW-1:0] msg_a [NREQ];
  logic [DW-1:0] exp_a [NREQ];
  logic [DW-1:0] mod_a [NREQ];

  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign msg_a[r] = req_msg_i[r*DW +: DW];
    assign exp_a[r] = req_exp_i[r*DW +: DW];
    assign mod_a[r] = req_mod_i[r*DW +: DW];
  end

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    return (v == GW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Highest set bit index + 1; zero for a zero exponent.
  function automatic logic [5:0] bit_len(input logic [DW-1:0] v);
    logic [5:0] len;
    len = '0;
    for (int i = 0; i < DW; i++) begin
      if (v[i]) len = 6'(i + 1);
    end
    return len;
  endfunction

  assign dbg_state_o = state;
  // The accept cycle is still IDLE, but a job is already owned then.
  assign busy_o      = (state != S_IDLE) || (|req_ready_o);

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && req_valid_i[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // Job sequencer: grant, operand checks, core handshake, timeout, response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      req_ready_o    <= '0;
      rsp_valid_o    <= '0;
      rsp_data_o     <= '0;
      rsp_err_o      <= 1'b0;
      core_init_o    <= 1'b0;
      core_next_o    <= 1'b0;
      core_msg_o     <= '0;
      core_exp_o     <= '0;
      core_mod_o     <= '0;
      core_exp_len_o <= '0;
      grant_o        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_ready_o) begin
            // Accept cycle: latched operands decide core run vs. direct answer.
            req_ready_o <= '0;
            if (core_mod_o == '0) begin
              rsp_valid_o <= onehot(grant_o);
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b1;
              state       <= S_RESP;
            end else if (core_exp_o == '0) begin
              rsp_valid_o <= onehot(grant_o);
              rsp_data_o  <= (core_mod_o == DW'(1)) ? '0 : DW'(1);
              rsp_err_o   <= 1'b0;
              state       <= S_RESP;
            end else if (core_mod_o == DW'(1)) begin
              rsp_valid_o <= onehot(grant_o);
              rsp_data_o  <= '0;
              rsp_err_o   <= 1'b0;
              state       <= S_RESP;
            end else begin
              core_init_o <= 1'b1;
              state       <= S_INIT;
            end
          end else if (pick_found) begin
            req_ready_o    <= onehot(pick_idx);
            grant_o        <= pick_idx;
            ptr            <= wrap_inc(pick_idx);
            core_msg_o     <= msg_a[pick_idx];
            core_exp_o     <= exp_a[pick_idx];
            core_mod_o     <= mod_a[pick_idx];
            core_exp_len_o <= bit_len(exp_a[pick_idx]);
          end
        end
        // Pulse cycle: core_ready_i is stale here and deliberately ignored.
        S_INIT: begin
          core_init_o <= 1'b0;
          cnt         <= '0;
          state       <= S_WAIT_INIT;
        end
        S_WAIT_INIT: begin
          if (core_ready_i) begin
            core_next_o <= 1'b1;
            state       <= S_NEXT;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid_o <= onehot(grant_o);
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEXT: begin
          core_next_o <= 1'b0;
          cnt         <= '0;
          state       <= S_WAIT_NEXT;
        end
        S_WAIT_NEXT: begin
          if (core_ready_i) begin
            rsp_valid_o <= onehot(grant_o);
            rsp_data_o  <= core_result_i;
            rsp_err_o   <= 1'b0;
            state       <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid_o <= onehot(grant_o);
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Only the owner's rsp_ready_i completes the response.
        S_RESP: begin
          if (rsp_ready_i[grant_o]) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_sched.sv
// Self-checking bench for rsa_modexp_sched with a behavioural core model.
module tb_rsa_modexp_sched;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TO   = 40;
  localparam int SB_W = NREQ + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ*DW-1:0] req_msg_i, req_exp_i, req_mod_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [NREQ-1:0]    rsp_ready_i;
  logic [DW-1:0]      rsp_data_o;
  logic               rsp_err_o;
  logic               core_init_o, core_next_o;
  logic               core_ready_i;
  logic [DW-1:0]      core_msg_o, core_exp_o, core_mod_o;
  logic [5:0]         core_exp_len_o;
  logic [DW-1:0]      core_result_i;
  logic               busy_o;
  logic [1:0]         grant_o;
  logic [2:0]         dbg_state_o;

  rsa_modexp_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_msg_i(req_msg_i), .req_exp_i(req_exp_i), .req_mod_i(req_mod_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .core_init_o(core_init_o), .core_next_o(core_next_o),
    .core_ready_i(core_ready_i),
    .core_msg_o(core_msg_o), .core_exp_o(core_exp_o), .core_mod_o(core_mod_o),
    .core_exp_len_o(core_exp_len_o), .core_result_i(core_result_i),
    .busy_o(busy_o), .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_init   = 0;
  int n_next   = 0;
  int rsp_seen = 0;
  bit hang     = 1'b0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;
  logic [3:0]      dly;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modexp_ref(input logic [31:0] m, input logic [31:0] e,
                                             input logic [31:0] n);
    logic [63:0] r, b, nn;
    nn = {32'b0, n};
    r  = 64'd1 % nn;
    b  = {32'b0, m} % nn;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[31:0];
  endfunction

  function automatic logic [5:0] ref_len(input logic [31:0] e);
    for (int i = 31; i >= 0; i--) begin
      if (e[i]) return 6'(i + 1);
    end
    return 6'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: drops ready on a pulse, raises it after a short latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready_i  <= 1'b1;
      dly           <= '0;
      core_result_i <= '0;
    end else if (core_init_o) begin
      core_ready_i <= 1'b0;
      dly          <= 4'd3;
    end else if (core_next_o) begin
      core_ready_i  <= 1'b0;
      dly           <= 4'd5;
      core_result_i <= modexp_ref(core_msg_o, core_exp_o, core_mod_o);
    end else if (!core_ready_i && !hang) begin
      if (dly == 0) core_ready_i <= 1'b1;
      else          dly <= dly - 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #1;
    n_init += int'(core_init_o);
    n_next += int'(core_next_o);
    if (|(rsp_valid_o & rsp_ready_i)) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, '0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_rsp(input int r, input logic err, input logic [31:0] d);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    exp_q.push_back({oh, err, d});
  endtask

  task automatic put_req(input int r, input logic [31:0] m, input logic [31:0] e,
                         input logic [31:0] n);
    req_msg_i[r*DW +: DW] = m;
    req_exp_i[r*DW +: DW] = e;
    req_mod_i[r*DW +: DW] = n;
    req_valid_i[r]        = 1'b1;
  endtask

  task automatic rand_job(output logic [31:0] m, output logic [31:0] e, output logic [31:0] n);
    m = $urandom;
    e = $urandom | 32'h1;
    n = $urandom_range(32'hFFFF_FFFF, 2) | 32'h2;
  endtask

  task automatic wait_grant(input int r, input logic [5:0] len);
    logic [NREQ-1:0] oh;
    bit got;
    oh    = '0;
    oh[r] = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (req_ready_o != '0) got = 1'b1;
    end
    check("grant_idx", req_ready_o, oh);
    if (got) begin
      check("grant_o", grant_o, r);
      check("exp_len", core_exp_len_o, len);
      req_valid_i = req_valid_i & ~req_ready_o;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0 && req_valid_i == '0) done = 1'b1;
    end
    if (!done) check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_ctl"}, {req_ready_o, rsp_valid_o, rsp_err_o, core_init_o, core_next_o,
                          busy_o, grant_o, core_exp_len_o, dbg_state_o}, '0);
    check({tag, "_data"}, {rsp_data_o, core_msg_o}, '0);
    check({tag, "_ops"}, {core_exp_o, core_mod_o}, '0);
  endtask

  task automatic degen(input int r, input logic [31:0] m, input logic [31:0] e,
                       input logic [31:0] n, input logic err, input logic [31:0] d,
                       input logic [5:0] len);
    logic [NREQ-1:0] oh;
    int base;
    oh    = '0;
    oh[r] = 1'b1;
    base  = n_init + n_next;
    expect_rsp(r, err, d);
    put_req(r, m, e, n);
    wait_grant(r, len);
    @(negedge clk);
    check("degen_latency", rsp_valid_o, oh);
    wait_idle();
    check("degen_no_core", n_init + n_next - base, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] t2_m [4];
  logic [31:0] t2_e [4];
  logic [31:0] t2_n [4];
  logic [31:0] t2_r [4];
  logic [31:0] m1, e1, n1, m3, e3, n3;
  int i0, x0, t0, s0;
  bit seen;

  initial begin
    t2_m = '{32'd1, 32'd2, 32'd2, 32'h0123_4567};
    t2_e = '{32'd2, 32'd2, 32'd2, 32'h89AB_CDEF};
    t2_n = '{32'd5, 32'd5, 32'd3, 32'h1111_1111};
    t2_r = '{32'd1, 32'd4, 32'd1, 32'h0D9E_F081};

    rst         = 1'b1;
    req_valid_i = '0;
    req_msg_i   = '0;
    req_exp_i   = '0;
    req_mod_i   = '0;
    rsp_ready_i = '1;
    repeat (3) @(negedge clk);
    check_zero_outs("reset");
    rst = 1'b0;

    // Single job on requester 0
    i0 = n_init;
    x0 = n_next;
    expect_rsp(0, 1'b0, 32'h1BD);
    put_req(0, 32'd4, 32'hD, 32'h1F1);
    wait_grant(0, 6'd4);
    check("core_ops", {core_msg_o, core_mod_o}, {32'd4, 32'h1F1});
    wait_idle();
    check("one_init", n_init - i0, 1);
    check("one_next", n_next - x0, 1);

    // Reset to put the round-robin pointer back at 0
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outs("reset2");
    @(negedge clk);
    rst = 1'b0;

    // Four simultaneous requesters
    for (int r = 0; r < 4; r++) begin
      expect_rsp(r, 1'b0, t2_r[r]);
      put_req(r, t2_m[r], t2_e[r], t2_n[r]);
    end
    for (int r = 0; r < 4; r++) wait_grant(r, ref_len(t2_e[r]));
    wait_idle();

    // Requesters 3 and 1 re-request: 1 must win first
    rand_job(m1, e1, n1);
    rand_job(m3, e3, n3);
    expect_rsp(1, 1'b0, modexp_ref(m1, e1, n1));
    expect_rsp(3, 1'b0, modexp_ref(m3, e3, n3));
    put_req(3, m3, e3, n3);
    put_req(1, m1, e1, n1);
    wait_grant(1, ref_len(e1));
    wait_grant(3, ref_len(e3));
    wait_idle();

    // Degenerate operands
    degen(2, 32'd9, 32'd0, 32'd7, 1'b0, 32'd1, 6'd0);
    degen(1, 32'd5, 32'd3, 32'd0, 1'b1, 32'd0, 6'd2);
    degen(3, 32'd6, 32'd5, 32'd1, 1'b0, 32'd0, 6'd3);
    degen(0, 32'd3, 32'd0, 32'd1, 1'b0, 32'd0, 6'd0);

    // Core hang during WAIT_INIT
    hang = 1'b1;
    rand_job(m1, e1, n1);
    expect_rsp(1, 1'b1, 32'd0);
    put_req(1, m1, e1, n1);
    wait_grant(1, ref_len(e1));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (core_init_o) seen = 1'b1;
    end
    check("hang_init_seen", core_init_o, 1'b1);
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < TO + 20 && !seen; i++) begin
      @(negedge clk);
      if (|rsp_valid_o) seen = 1'b1;
    end
    check("hang_latency", cyc - t0, TO + 1);
    wait_idle();
    hang = 1'b0;
    rand_job(m1, e1, n1);
    expect_rsp(0, 1'b0, modexp_ref(m1, e1, n1));
    put_req(0, m1, e1, n1);
    wait_grant(0, ref_len(e1));
    wait_idle();

    // Response backpressure with a competing request pending
    rsp_ready_i = '0;
    expect_rsp(0, 1'b0, 32'h1BD);
    put_req(0, 32'd4, 32'hD, 32'h1F1);
    wait_grant(0, 6'd4);
    rand_job(m1, e1, n1);
    expect_rsp(1, 1'b0, modexp_ref(m1, e1, n1));
    put_req(1, m1, e1, n1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid_o[0]) seen = 1'b1;
    end
    check("bp_valid", rsp_valid_o, 4'b0001);
    rsp_ready_i[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid_o, req_ready_o, rsp_err_o, rsp_data_o},
            {4'b0001, 4'b0000, 1'b0, 32'h1BD});
    end
    rsp_ready_i = '1;
    wait_grant(1, ref_len(e1));
    wait_idle();

    // Reset in the middle of WAIT_NEXT
    rand_job(m1, e1, n1);
    put_req(2, m1, e1, n1);
    wait_grant(2, ref_len(e1));
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (core_next_o) seen = 1'b1;
    end
    check("midjob_next_seen", core_next_o, 1'b1);
    @(negedge clk);
    rst         = 1'b1;
    req_valid_i = '0;
    #1;
    check_zero_outs("midjob_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0  = rsp_seen;
    repeat (30) @(negedge clk);
    check("no_rsp_after_rst", rsp_seen - s0, 0);
    check("idle_after_rst", {busy_o, dbg_state_o}, '0);
    rand_job(m1, e1, n1);
    rand_job(m3, e3, n3);
    expect_rsp(0, 1'b0, modexp_ref(m1, e1, n1));
    expect_rsp(2, 1'b0, modexp_ref(m3, e3, n3));
    put_req(2, m3, e3, n3);
    put_req(0, m1, e1, n1);
    wait_grant(0, ref_len(e1));
    wait_grant(2, ref_len(e3));
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_sched.md
# rsa_modexp_sched

Job scheduler that shares one 32-bit RSA modular-exponentiation core among `NREQ` requesters. It arbitrates round-robin, latches the winning operands, and computes the exponent bit length. It then sequences the core's init/next handshake and returns the result to the winning requester. It sits between the per-requester AXI4-lite register front ends and the single modexp datapath, and handles degenerate operands and core hangs itself.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DW`, 32, operand/result width
- `TIMEOUT`, 65535, max cycles waited on `core_ready_i` per phase
---
- `clk_i` in 1 — clock, all logic on rising edge
- `rst_i` in 1 — asynchronous, active-high reset
- `req_valid_i` in NREQ — job request per requester
- `req_ready_o` out NREQ — job accepted (one-hot, one cycle)
- `req_msg_i`/`req_exp_i`/`req_mod_i` in NREQ*DW each — operands, requester r at bits [r*DW +: DW]
- `rsp_valid_o` out NREQ — result valid (one-hot)
- `rsp_ready_i` in NREQ — requester consumes result
- `rsp_data_o` out DW — result (shared bus, valid with `rsp_valid_o`)
- `rsp_err_o` out 1 — error flag, valid with `rsp_valid_o`
- `core_init_o` / `core_next_o` out 1 — single-cycle start pulses to core
- `core_ready_i` in 1 — core idle/done (high when idle)
- `core_msg_o`/`core_exp_o`/`core_mod_o` out DW — latched operands
- `core_exp_len_o` out 6 — exponent length in bits
- `core_result_i` in DW — core result, valid when `core_ready_i` high after next
- `busy_o` out 1 — FSM not in IDLE
- `grant_o` out clog2(NREQ) — index of current job owner

## Operation
- States: IDLE, INIT, WAIT_INIT, NEXT, WAIT_NEXT, RESP.
- IDLE: if any `req_valid_i`, grant first requester at or after `ptr` (round-robin, wrapping). Pulse `req_ready_o[g]`, latch operands, set `grant_o`=g, set `ptr`=(g+1) mod NREQ.
- Operand checks happen in the accept cycle and the next state is chosen from them:
  - mod==0 → RESP, err=1, data=0.
  - exp==0 → RESP, err=0, data = (mod==1) ? 0 : 1.
  - mod==1 → RESP, err=0, data=0.
  - otherwise → INIT.
- `core_exp_len_o` = index of MSB of exp + 1 (1..32). It is held 0 when exp==0.
- INIT: assert `core_init_o` one cycle → WAIT_INIT.
- WAIT_INIT: when `core_ready_i` high → NEXT.
- NEXT: assert `core_next_o` one cycle → WAIT_NEXT.
- WAIT_NEXT: when `core_ready_i` high, latch `core_result_i` → RESP with err=0.
- Timeout: a counter clears on entry to each WAIT state and increments each cycle there. When it reaches TIMEOUT → RESP with err=1, data=0.
- RESP: hold `rsp_valid_o[g]`, `rsp_data_o`, `rsp_err_o` stable until `rsp_ready_i[g]`, then → IDLE. Other requesters' `rsp_ready_i` are ignored.
- Requests arriving while busy wait. `req_valid_i` must stay high until the request is accepted.
- Reset (any state, including mid-job):
  - all outputs 0, `ptr`=0, state IDLE, counters 0.
  - An in-flight job is dropped with no response.

## Timing
- Accept: `req_ready_o` rises the same cycle the FSM sees valid in IDLE (registered grant; ready high exactly one cycle).
- Normal job:
  - `core_init_o` asserts the cycle after accept.
  - `core_next_o` asserts 1 cycle after `core_ready_i` is sampled high in WAIT_INIT.
  - `rsp_valid_o` rises 1 cycle after `core_ready_i` is sampled high in WAIT_NEXT.
- Degenerate job: `rsp_valid_o` rises the cycle after accept (latency 1).
- `core_ready_i` is ignored in the cycle a pulse is issued. WAIT states sample from the following cycle, so a stale ready cannot skip the core.
- Back-to-back: after the RESP handshake cycle the FSM is in IDLE. The next accept can occur the following cycle, so a requester is never accepted twice in a row while another is waiting.
- Core operand outputs are stable from INIT until the next accept.

## Test plan
- Single requester 0: msg=4, exp=0xD, mod=0x1F1. Expect: `core_exp_len_o`=4; `rsp_data_o`=0x1BD, err=0 on `rsp_valid_o[0]`; exactly one init and one next pulse.
- All four requesters valid simultaneously, with jobs 1^2 mod 5, 2^2 mod 5, 2^2 mod 3, 0x01234567^0x89ABCDEF mod 0x11111111. Expect grants in order 0,1,2,3 and results 1, 4, 1, 0x0D9EF081. Then requesters 3 and 1 re-request: grant 1 before 3.
- Degenerate operands:
  - exp=0, mod=7 → data=1, err=0, latency 1, no core pulses.
  - mod=0 → data=0, err=1.
  - mod=1, exp=5 → data=0, err=0.
- Core hang: `core_ready_i` held low after init. Expect err=1, data=0 exactly TIMEOUT cycles into WAIT_INIT; a subsequent normal job completes correctly.
- Response backpressure: `rsp_ready_i` held low for 20 cycles. Expect data/err stable, no new grant. Drive `rsp_ready_i[g+1]` high meanwhile → no effect.
- Assert `rst_i` during WAIT_NEXT. Expect: all outputs 0 immediately; no response after release; next job granted to requester 0 first.
